vga_timing_gen: RTL
===================

# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing on `vga_clk`. Outputs the pixel coordinates `DrawX`/`DrawY` and the visible-area flag `blank` that every sprite renderer and palette stage consumes. Also drives the monitor's `hsync`/`vsync`, delayed to stay aligned with the renderers' registered colour outputs. Sits between the clock/reset block and all sprite/background renderers; also provides frame and line strobes plus a frame counter for animation.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (clocks)
- `H_SYNC`, 96: hsync pulse width (clocks)
- `H_BP`, 48: horizontal back porch; H_TOTAL = sum = 800
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vsync pulse width (lines)
- `V_BP`, 33: vertical back porch; V_TOTAL = sum = 525
- `SYNC_DLY`, 1: pipeline stages applied to `hsync_o`/`vsync_o`/`blank_o` (0..4); matches renderer colour latency
- `vga_clk`  in  1  pixel clock; the only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `DrawX`  out  10  current pixel column, 0..H_TOTAL-1
- `DrawY`  out  10  current line, 0..V_TOTAL-1
- `blank`  out  1  1 = (DrawX, DrawY) is visible; renderers output colour only when high
- `line_start`  out  1  one-cycle pulse when DrawX==0
- `frame_start`  out  1  one-cycle pulse when DrawX==0 && DrawY==0
- `frame_cnt`  out  8  frames since reset, wraps 255->0
- `hsync_o`  out  1  active-low hsync, delayed SYNC_DLY cycles
- `vsync_o`  out  1  active-low vsync, delayed SYNC_DLY cycles
- `blank_o`  out  1  `blank` delayed SYNC_DLY cycles, for the DAC/encoder

## Operation
- Horizontal counter `hc` runs 0..H_TOTAL-1. At H_TOTAL-1 it wraps to 0, and vertical counter `vc` increments. `vc` wraps from V_TOTAL-1 to 0 when `hc` wraps.
- `DrawX`=`hc` and `DrawY`=`vc` come straight from the registers.
- `blank`, `line_start`, `frame_start` and the undelayed syncs are registered decodes of the next counter values. They are therefore valid in the same cycle as the matching `DrawX`/`DrawY`.
- `blank` = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- hsync is low for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
- vsync is low for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491], across entire lines.
- `frame_cnt` increments in the cycle `frame_start` is asserted. It is unsigned 8-bit and wraps.
- Delay line: a SYNC_DLY-deep shift register carries {hsync, vsync, blank}. With SYNC_DLY=0 the outputs equal the undelayed signals combinationally.

## Timing
- Reset values, asserted while `reset_n` is low:
  - `hc`=H_TOTAL-1 (799), `vc`=V_TOTAL-1 (524), so `DrawX`=799, `DrawY`=524.
  - `blank`=0, `line_start`=0, `frame_start`=0, `frame_cnt`=0.
  - Every delay stage and `hsync_o`/`vsync_o`=1, `blank_o`=0.
- First rising edge after release: `DrawX`=0, `DrawY`=0, `blank`=1, `line_start`=1, `frame_start`=1, `frame_cnt`=1. No visible pixel of frame 0 is lost.
- Line period: 800 clocks. Frame period: 420000 clocks. `frame_start` repeats exactly every 420000 cycles.
- `hsync_o`/`vsync_o`/`blank_o` lag the undelayed decode by exactly SYNC_DLY cycles.
- Reset mid-frame: all state returns to reset values immediately (async). After release, behaviour is identical to power-up.
- No handshake. Outputs are free-running every cycle.

## Structure
- Shared package `vga_timing_pkg`: the eight H/V constants, derived H_TOTAL/V_TOTAL, sync start/end constants, and the 10-bit coordinate typedef. Renderers import the same package.
- One sub-module, `sync_delay_line`: a parameterised width/depth shift register with async active-low reset and a per-bit reset value. It is instantiated once with width 3.
- Elaboration check: SYNC_DLY <= 4, and H_TOTAL, V_TOTAL <= 1024.

## Test plan
- Release reset, sample first edge: DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1, hsync_o=1, vsync_o=1.
- Run one line: blank falls when DrawX=640. hsync low for DrawX 656..751, exactly 96 cycles, seen on hsync_o SYNC_DLY cycles later. line_start high only when DrawX=0.
- Run one frame: blank=0 for DrawY>=480. vsync_o low for exactly 1600 clocks (lines 490..491). DrawY=524 to 0 at wrap, with frame_start 420000 cycles after the previous one.
- Run 256 frames: frame_cnt reaches 255, then 0 on the next frame_start.
- SYNC_DLY=0 vs 3: blank_o equals blank in the same cycle, versus exactly 3 cycles later. Reset values are held during the pipeline fill.
- Assert reset_n low at DrawX=300, DrawY=200 for 5 cycles: outputs take reset values immediately. After release, the sequence matches power-up from (0,0).

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing_pkg : 640x480@60 raster constants and coordinate type     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_HSYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_HSYNC_END   = VGA_HSYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_VSYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_VSYNC_END   = VGA_VSYNC_START + VGA_V_SYNC - 1;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    function automatic coord_t wrap_inc(input coord_t v, input coord_t last);
        return (v == last) ? '0 : v + coord_t'(1);
    endfunction

    function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_delay_line : WIDTH x DEPTH shift register, per-bit reset value  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sync_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= RESET_VAL;
                    end
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing_gen : raster counters, visible/sync decode, frame counter |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int SYNC_DLY = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output coord_t     DrawX,
    output coord_t     DrawY,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       blank_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [2:0] DLY_RESET_VAL = 3'b110;

    generate
        if (SYNC_DLY < 0 || SYNC_DLY > 4 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_param_check
            $error("vga_timing_gen: SYNC_DLY must be 0..4 and H/V totals must fit 10 bits");
        end
    endgenerate

    coord_t     hc;
    coord_t     vc;
    coord_t     hc_next;
    coord_t     vc_next;
    logic       frame_next;
    logic       hsync;
    logic       vsync;
    logic [2:0] dly_out;

    always_comb begin
        hc_next = wrap_inc(hc, H_LAST);
        vc_next = vc;
        if (hc == H_LAST) begin
            vc_next = wrap_inc(vc, V_LAST);
        end
        frame_next = (hc_next == '0) && (vc_next == '0);
    end

    // Decodes are taken from the next counter values so they line up with DrawX/DrawY.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc          <= H_LAST;
            vc          <= V_LAST;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
        end else begin
            hc          <= hc_next;
            vc          <= vc_next;
            blank       <= (hc_next < H_VIS) && (vc_next < V_VIS);
            line_start  <= (hc_next == '0);
            frame_start <= frame_next;
            if (frame_next) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            hsync       <= !in_range(hc_next, HS_START, HS_END);
            vsync       <= !in_range(vc_next, VS_START, VS_END);
        end
    end

    assign DrawX = hc;
    assign DrawY = vc;

    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (SYNC_DLY),
        .RESET_VAL (DLY_RESET_VAL)
    ) u_sync_dly (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .din   ({hsync, vsync, blank}),
        .dout  (dly_out)
    );

    assign {hsync_o, vsync_o, blank_o} = dly_out;

endmodule
`default_nettype wire
